// File: rtl/gf163_pkg.sv
// Shared GF(2^163) constants, FSM encoding and a divide-by-x helper.
// Field polynomial f(x) = x^163 + x^80 + x^47 + x^9 + 1.
package gf163_pkg;

  localparam int unsigned M = 163;

  localparam logic [M:0] F_POLY = (164'(1) << 163) | (164'(1) << 80) | (164'(1) << 47) |
                                  (164'(1) << 9) | 164'(1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFin
  } inv_state_e;

  // g * x^-1 mod f: make g even by adding f, then shift; the result always fits in M bits.
  function automatic logic [M-1:0] div_x(input logic [M-1:0] g);
    logic [M:0] t;
    t = g[0] ? ({1'b0, g} ^ F_POLY) : {1'b0, g};
    return t[M:1];
  endfunction

endpackage

// File: rtl/gf163_msb_index.sv
// Combinational leading-one detector: index of the highest set bit (0 when val is 0).
module gf163_msb_index (
  input  logic [163:0] val,
  output logic [7:0]   idx
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < 164; i++) begin
      if (val[i]) idx = 8'(i);
    end
  end

endmodule

// File: rtl/gf163_inverter.sv
// GF(2^163) inverter using the binary extended Euclidean algorithm, one step per cycle.
// Invariants: g1*a == u and g2*a == v (mod f); finishes when u or v reaches 1.
module gf163_inverter #(
  parameter int unsigned M       = gf163_pkg::M,
  parameter int unsigned MAX_CYC = 4 * M
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] a,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] c,
  output logic         err
);
  import gf163_pkg::*;

  localparam int unsigned W = M + 1;

  inv_state_e   state_q, state_d;
  logic [W-1:0] u_q, u_d, v_q, v_d;
  logic [M-1:0] g1_q, g1_d, g2_q, g2_d;
  logic [M-1:0] c_q, c_d;
  logic         err_q, err_d;
  logic [9:0]   cnt_q, cnt_d;
  logic [7:0]   deg_u, deg_v;

  gf163_msb_index u_msb_u (
    .val (u_q),
    .idx (deg_u)
  );

  gf163_msb_index u_msb_v (
    .val (v_q),
    .idx (deg_v)
  );

  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    v_d     = v_q;
    g1_d    = g1_q;
    g2_d    = g2_q;
    c_d     = c_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d = '0;
          if (a == '0) begin
            state_d = StFin;
            c_d     = '0;
            err_d   = 1'b1;
          end else begin
            state_d = StRun;
            u_d     = {1'b0, a};
            v_d     = F_POLY;
            g1_d    = M'(1);
            g2_d    = '0;
          end
        end
      end
      StRun: begin
        if (u_q == W'(1)) begin
          state_d = StFin;
          c_d     = g1_q;
          err_d   = 1'b0;
        end else if (v_q == W'(1)) begin
          state_d = StFin;
          c_d     = g2_q;
          err_d   = 1'b0;
        end else if (cnt_q == 10'(MAX_CYC)) begin
          state_d = StFin;
          c_d     = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 10'd1;
          if (!u_q[0]) begin
            u_d  = u_q >> 1;
            g1_d = div_x(g1_q);
          end else if (!v_q[0]) begin
            v_d  = v_q >> 1;
            g2_d = div_x(g2_q);
          end else if (deg_u >= deg_v) begin
            u_d  = u_q ^ v_q;
            g1_d = g1_q ^ g2_q;
          end else begin
            v_d  = v_q ^ u_q;
            g2_d = g2_q ^ g1_q;
          end
        end
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      u_q     <= '0;
      v_q     <= '0;
      g1_q    <= '0;
      g2_q    <= '0;
      c_q     <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      v_q     <= v_d;
      g1_q    <= g1_d;
      g2_q    <= g2_d;
      c_q     <= c_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StFin);
  assign c    = c_q;
  assign err  = err_q;

endmodule

// File: tb/tb_gf163_inverter.sv
// Self-checking bench for gf163_inverter: vector table, random operands against an
// exponentiation-based reference (a^-1 = a^(2^163-2)), reset and start-while-busy sequences.
module tb_gf163_inverter;

  localparam int MAX_LAT = 654;
  localparam int TIMEOUT = 700;
  localparam logic [162:0] RED = (163'(1) << 80) | (163'(1) << 47) | (163'(1) << 9) | 163'(1);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [162:0] a = '0;
  logic         busy, done, err;
  logic [162:0] c;

  int checks = 0;
  int errors = 0;

  gf163_inverter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .busy  (busy),
    .done  (done),
    .c     (c),
    .err   (err)
  );

  always #5 clk = ~clk;

  function automatic logic [162:0] gf_mul(input logic [162:0] x, input logic [162:0] y);
    logic [162:0] r, b;
    logic         msb;
    r = '0;
    b = x;
    for (int i = 0; i < 163; i++) begin
      if (y[i]) r ^= b;
      msb = b[162];
      b = b << 1;
      if (msb) b ^= RED;
    end
    return r;
  endfunction

  // Fermat: a^(2^163-2) = (a^(2^162-1))^2
  function automatic logic [162:0] gf_inv(input logic [162:0] x);
    logic [162:0] b;
    if (x == '0) return '0;
    b = x;
    for (int k = 0; k < 161; k++) b = gf_mul(gf_mul(b, b), x);
    return gf_mul(b, b);
  endfunction

  task automatic check(input string name, input logic [162:0] act, input logic [162:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one start and wait for done; also watches that c stays put while busy.
  task automatic do_op(input logic [162:0] av, output logic [162:0] cv, output logic ev,
                       output int lat);
    logic [162:0] prev_c;
    logic         c_moved;
    prev_c  = c;
    c_moved = 1'b0;
    @(negedge clk);
    start = 1'b1;
    a     = av;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < TIMEOUT) begin
      if (busy && c !== prev_c) c_moved = 1'b1;
      @(negedge clk);
      lat++;
    end
    cv = c;
    ev = err;
    check("c_stable_while_busy", 163'(c_moved), 163'(0));
    check("done_reached", 163'(done), 163'(1));
  endtask

  typedef struct {
    logic [162:0] a;
    logic [162:0] c;
    logic         err;
    int           lat;  // exact latency, or 0 for "within MAX_LAT"
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [162:0] cv, r, held;
    logic         ev;
    int           lat;
    bit           saw_done;

    vecs[0] = '{a: 163'(1), c: 163'(1), err: 1'b0, lat: 2};
    vecs[1] = '{a: 163'h2,
                c: (163'(1) << 162) | (163'(1) << 79) | (163'(1) << 46) | (163'(1) << 8),
                err: 1'b0, lat: 0};
    vecs[2] = '{a: 163'(0), c: 163'(0), err: 1'b1, lat: 1};
    vecs[3] = '{a: 163'(1) << 162, c: gf_inv(163'(1) << 162), err: 1'b0, lat: 0};
    vecs[4] = '{a: {163{1'b1}}, c: gf_inv({163{1'b1}}), err: 1'b0, lat: 0};

    repeat (3) @(negedge clk);
    check("reset_busy", 163'(busy), 163'(0));
    check("reset_done", 163'(done), 163'(0));
    check("reset_c", c, 163'(0));
    check("reset_err", 163'(err), 163'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      do_op(vecs[i].a, cv, ev, lat);
      check($sformatf("vec%0d_c", i), cv, vecs[i].c);
      check($sformatf("vec%0d_err", i), 163'(ev), 163'(vecs[i].err));
      if (vecs[i].lat != 0) check($sformatf("vec%0d_lat", i), 163'(lat), 163'(vecs[i].lat));
      else check($sformatf("vec%0d_lat_bound", i), 163'(lat <= MAX_LAT), 163'(1));
      if (vecs[i].err == 1'b0 && vecs[i].a != '0)
        check($sformatf("vec%0d_product", i), gf_mul(vecs[i].a, cv), 163'(1));
      held = c;
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), 163'(done), 163'(0));
      check($sformatf("vec%0d_c_held", i), c, held);
    end

    for (int n = 0; n < 16; n++) begin
      for (int w = 0; w < 6; w++) r[w*32 +: 32] = (w == 5) ? 32'($urandom & 32'h7) : $urandom;
      if (r == '0) r = 163'h5;
      do_op(r, cv, ev, lat);
      check($sformatf("rand%0d_c", n), cv, gf_inv(r));
      check($sformatf("rand%0d_err", n), 163'(ev), 163'(0));
      check($sformatf("rand%0d_lat", n), 163'(lat <= MAX_LAT), 163'(1));
    end

    // Reset for one cycle mid-RUN, with start held during reset
    do_op(163'h2, cv, ev, lat);
    @(negedge clk);
    start = 1'b1;
    a     = {163{1'b1}};
    @(negedge clk);
    start = 1'b0;
    saw_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("pre_reset_busy", 163'(busy), 163'(1));
    rst_n = 1'b0;
    start = 1'b1;
    a     = 163'(1);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    check("rst_busy", 163'(busy), 163'(0));
    check("rst_c", c, 163'(0));
    check("rst_err", 163'(err), 163'(0));
    repeat (10) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("rst_no_done", 163'(saw_done), 163'(0));
    do_op(163'h2, cv, ev, lat);
    check("post_rst_c", cv, vecs[1].c);

    // Start pulsed while busy is ignored; start during FIN ignored; IDLE after FIN accepted
    @(negedge clk);
    start = 1'b1;
    a     = 163'(1) << 162;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    repeat (3) begin
      @(negedge clk);
      lat++;
    end
    start = 1'b1;
    a     = 163'h2;
    @(negedge clk);
    lat++;
    start = 1'b0;
    while (!done && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
    check("busy_start_done", 163'(done), 163'(1));
    check("busy_start_c", c, vecs[3].c);
    check("busy_start_err", 163'(err), 163'(0));
    start = 1'b1;
    a     = 163'(0);
    @(negedge clk);
    a = 163'(1);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 163'(busy), 163'(1));
    @(negedge clk);
    check("b2b_done", 163'(done), 163'(1));
    check("b2b_c", c, 163'(1));
    check("b2b_err", 163'(err), 163'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gf163_inverter.md
GF163_INVERTER -- requirements
Module: gf163_inverter

Interface
REQ-001 SHALL have parameters: M, 163, field degree; MAX_CYC, 652, watchdog bound in cycles (4*M).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port start  input  1  request; sampled only while busy=0.
REQ-005 SHALL have port a  input  163  operand, polynomial basis (bit i = coeff of x^i); sampled in the start cycle.
REQ-006 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-007 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-008 SHALL have port c  output  163  a^-1 mod f(x); held from done until the next accepted start.
REQ-009 SHALL have port err  output  1  set with done when a=0 or watchdog expired; held with c.

Function
REQ-010 SHALL compute c such that a*c = 1 mod f(x), f = x^163 + x^80 + x^47 + x^9 + 1, same field as karatsuba_163x163.
REQ-011 SHALL use binary extended Euclid: u=a, v=f (164 bit), g1=1, g2=0 at load.
REQ-012 SHALL perform exactly one step per RUN cycle, priority: u[0]=0 -> u>>=1, g1 = (g1[0] ? g1^f : g1)>>1; else v[0]=0 -> same on v,g2; else deg(u)>=deg(v) -> u^=v, g1^=g2; else v^=u, g2^=g1.
REQ-013 SHALL terminate when u=1 (c=g1) or v=1 (c=g2); u=1 wins when both are 1 in the same cycle.
REQ-014 SHALL use FSM IDLE -> RUN (start & a!=0) | FIN (start & a=0) ; RUN -> FIN on termination or cycle count = MAX_CYC ; FIN -> IDLE unconditionally.
REQ-015 SHALL assert done=1 for exactly the FIN cycle, with c/err registered in that same cycle.
REQ-016 SHALL in FIN for a=0 drive c=0, err=1; on watchdog drive c=0, err=1; otherwise err=0.
REQ-017 SHALL have latency from start to done at most MAX_CYC+2 cycles; a=1 SHALL complete in exactly 2 cycles (start cycle, FIN).
REQ-018 SHALL ignore start while busy=1 or in FIN; no queuing.
REQ-019 SHALL accept a start in the IDLE cycle directly following FIN (back-to-back).
REQ-020 SHALL keep c, err unchanged while busy, until the new FIN.
REQ-021 SHALL bound the step counter to 10 bits, cleared on each accepted start.

Reset
REQ-022 SHALL with rst_n=0 at a clock edge force IDLE, busy=0, done=0, c=0, err=0, counter=0, u/v/g1/g2=0.
REQ-023 SHALL abort an in-flight inversion on reset with no done pulse.
REQ-024 SHALL ignore start in any cycle where rst_n=0.

Structure
REQ-025 SHALL take M, the 164-bit constant F_POLY and the FSM state enum from shared package gf163_pkg, also used by the multiplier benches.
REQ-026 SHALL place the leading-one detector (164-bit in, 8-bit degree out, combinational) in sub-module gf163_msb_index, instantiated twice.
REQ-027 SHALL contain no multiplier instance; datapath is shift/XOR only.

Verification
REQ-028 SHALL cover: a=1 -> done 2 cycles after start, c=1, err=0.
REQ-029 SHALL cover: a=163'h2 -> c = x^162+x^79+x^46+x^8, err=0.
REQ-030 SHALL cover: a=0 -> done in the cycle after start, c=0, err=1.
REQ-031 SHALL cover: a=x^162, and a=163'h7ff..f (all ones) -> karatsuba_163x163(a,c)=1, latency <= 654 cycles.
REQ-032 SHALL cover: rst_n low for 1 cycle mid-RUN -> no done; busy=0, c=0 after the edge; next start (a=2) still correct.
REQ-033 SHALL cover: start pulsed while busy with different a -> ignored, result matches the first operand; start in the IDLE cycle after FIN is accepted.
